sklansky_frame_acc: RTL and testbench
=====================================

Name: sklansky_frame_acc

Overview:
- Sequential accumulator directly downstream of the team's 6-bit Sklansky prefix adder (`sklansky_all`).
- Consumes a framed stream of 6-bit operands and folds each one into a running 6-bit sum using one `sklansky_all` instance as its combinational core.
- Presents the frame result (sum, overflow flag, term count) on a valid/ready output handshake.
- Is the first clocked stage around the adder datapath.

Parameters:
- CNT_W, 4, width of the per-frame term counter; the counter saturates at 2^CNT_W-1.

Ports:
- i_clk  input  1  clock, all state changes on the rising edge.
- i_rst  input  1  synchronous, active-high reset.
- i_valid  input  1  operand valid.
- o_ready  output  1  block can accept an operand this cycle.
- i_data  input  6  operand.
- i_last  input  1  marks the final operand of a frame; qualified by i_valid & o_ready.
- o_valid  output  1  frame result valid.
- i_ready  input  1  downstream accepts the result.
- o_sum  output  6  accumulated frame sum.
- o_ovf  output  1  at least one carry-out occurred during the frame.
- o_cnt  output  CNT_W  number of operands accepted in the frame (saturating).

Behaviour:
- Clocking and reset:
  - One clock. Reset is synchronous and active-high (i_rst sampled on the rising edge of i_clk).
  - Reset values: state=ACC, acc=0, ovf=0, cnt=0, o_valid=0, o_ready=1, o_sum=0, o_ovf=0, o_cnt=0.
  - i_rst asserted mid-frame or while in DONE discards everything; no result is emitted.
- Adder core:
  - `sklansky_all` with i_x=acc, i_y=i_data; its outputs are sum_c[5:0] and carry_c.
- State ACC:
  - o_ready=1, o_valid=0.
  - On accept (i_valid & o_ready): acc<=sum_c; ovf<=ovf|carry_c; cnt<=cnt+1, holding at all-ones.
  - Accept with i_last=0: stay in ACC.
  - Accept with i_last=1: go to DONE. The final operand's contribution is included in the result.
  - i_valid=0: all state holds.
- State DONE:
  - o_valid=1, o_ready=0. i_data, i_last and i_valid are ignored.
  - o_sum=acc, o_ovf=ovf, o_cnt=cnt, all held stable until the handshake completes.
  - On i_valid... on o_valid & i_ready: acc<=0, ovf<=0, cnt<=0, return to ACC. The next operand can be accepted in the following cycle.
  - i_ready held low: stall indefinitely with outputs stable.
- Latency:
  - Result is valid in the cycle after the i_last beat is accepted.
  - Throughput: one operand per cycle within a frame; one bubble cycle per frame (in DONE).
- Output values in ACC:
  - o_sum, o_ovf and o_cnt show the live accumulator state.
  - They are don't-care for downstream while o_valid=0.
- Boundary cases:
  - Single-operand frame (first beat has i_last=1): result is that operand, cnt=1, ovf=0.
  - 6-bit wrap: 63+1 gives o_sum=0 and sets ovf.
  - ovf is sticky across the rest of the frame.
  - cnt saturates at 2^CNT_W-1; accumulation continues unaffected.

Optional Feature:
- SKLANSKY_FRAME_ACC_SAT_EN
  - Defined: when carry_c=1 on an accept, acc is loaded with 6'h3F instead of sum_c. acc remains 6'h3F for the rest of the frame, because any further add into 6'h3F with nonzero data also carries; adding 0 leaves it at 6'h3F. ovf is still set.
  - Undefined: modulo-64 wrap as described in Behaviour.

Decomposition:
- Shared package `sklansky_pkg` holds:
  - localparam DATA_W=6
  - state enum {ACC, DONE} (1-bit encoding)
  - SAT_VAL=6'h3F
- Natural sub-module: the existing `sklansky_all`, instantiated once. No new sub-module.
- FSM and registers stay in this block.

Test Plan:
- Reset, then frame 5, 10, 20 (last on 20) with i_ready=1 -> o_valid one cycle after the last beat; o_sum=35, o_ovf=0, o_cnt=3; o_ready=0 during that cycle.
- Frame 40, 30 (last) -> wrap: o_sum=6, o_ovf=1, o_cnt=2. With SKLANSKY_FRAME_ACC_SAT_EN defined -> o_sum=63, o_ovf=1.
- Single-beat frame 63 with i_last=1; i_ready held low for 4 cycles -> o_valid stays 1, o_sum=63 stable, o_ready=0 and i_valid ignored; completes when i_ready rises; next frame starts from acc=0.
- 17 operands of value 1 with CNT_W=4 -> o_cnt=15 (saturated), o_sum=17, o_ovf=0.
- Assert i_rst after 2 beats of a frame (values 7 and 8), then send frame 9 (last) -> only one result emitted: o_sum=9, o_cnt=1.
- Back-to-back frames with i_valid continuously high -> exactly one stall cycle per frame; sums of consecutive frames are independent.

Source files
------------

// File: rtl/sklansky_pkg.sv
// Shared types and constants for the Sklansky adder datapath and its frame accumulator.
package sklansky_pkg;

  localparam int DATA_W = 6;
  localparam int LEVELS = $clog2(DATA_W);
  localparam logic [DATA_W-1:0] SAT_VAL = 6'h3F;

  typedef enum logic {
    ACC  = 1'b0,
    DONE = 1'b1
  } state_t;

endpackage

// File: rtl/sklansky_all.sv
// 6-bit Sklansky parallel-prefix adder (carry-in tied to zero), purely combinational.
module sklansky_all
  import sklansky_pkg::*;
(
  input  logic [DATA_W-1:0] i_x,
  input  logic [DATA_W-1:0] i_y,
  output logic [DATA_W-1:0] o_sum,
  output logic              o_cout
);

  logic [DATA_W-1:0] gen;
  logic [DATA_W-1:0] prp;
  logic [DATA_W-1:0] grp_g;
  logic [DATA_W-1:0] grp_p;

  // In-place prefix tree: at level l, the upper half of each 2^(l+1) group
  // merges with the topmost bit of the lower half, which this level never rewrites.
  always_comb begin
    gen   = i_x & i_y;
    prp   = i_x ^ i_y;
    grp_g = gen;
    grp_p = prp;
    for (int l = 0; l < LEVELS; l++) begin
      for (int i = 0; i < DATA_W; i++) begin
        if (((i >> l) & 1) == 1) begin
          grp_g[i] = grp_g[i] | (grp_p[i] & grp_g[((i >> l) << l) - 1]);
          grp_p[i] = grp_p[i] & grp_p[((i >> l) << l) - 1];
        end
      end
    end
    o_sum  = prp ^ {grp_g[DATA_W-2:0], 1'b0};
    o_cout = grp_g[DATA_W-1];
  end

endmodule

// File: rtl/sklansky_frame_acc.sv
// Framed accumulator around sklansky_all with valid/ready result handshake.
// Optional macro SKLANSKY_FRAME_ACC_SAT_EN: saturate the sum at SAT_VAL instead of wrapping.
module sklansky_frame_acc
  import sklansky_pkg::*;
#(
  parameter int CNT_W = 4
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_valid,
  output logic              o_ready,
  input  logic [DATA_W-1:0] i_data,
  input  logic              i_last,
  output logic              o_valid,
  input  logic              i_ready,
  output logic [DATA_W-1:0] o_sum,
  output logic              o_ovf,
  output logic [CNT_W-1:0]  o_cnt
);

  state_t            state, state_n;
  logic [DATA_W-1:0] acc, acc_n;
  logic              ovf, ovf_n;
  logic [CNT_W-1:0]  cnt, cnt_n;
  logic [DATA_W-1:0] sum_c;
  logic              carry_c;
  logic              accept;

  sklansky_all u_add (
    .i_x    (acc),
    .i_y    (i_data),
    .o_sum  (sum_c),
    .o_cout (carry_c)
  );

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state <= ACC;
      acc   <= '0;
      ovf   <= 1'b0;
      cnt   <= '0;
    end else begin
      state <= state_n;
      acc   <= acc_n;
      ovf   <= ovf_n;
      cnt   <= cnt_n;
    end
  end

  always_comb begin
    state_n = state;
    acc_n   = acc;
    ovf_n   = ovf;
    cnt_n   = cnt;
    o_ready = 1'b0;
    o_valid = 1'b0;
    accept  = 1'b0;
    case (state)
      ACC: begin
        o_ready = 1'b1;
        accept  = i_valid;
        if (accept) begin
`ifdef SKLANSKY_FRAME_ACC_SAT_EN
          acc_n = carry_c ? SAT_VAL : sum_c;
`else
          acc_n = sum_c;
`endif
          ovf_n = ovf | carry_c;
          if (cnt != {CNT_W{1'b1}}) cnt_n = cnt + CNT_W'(1);
          if (i_last) state_n = DONE;
        end
      end
      DONE: begin
        o_valid = 1'b1;
        if (i_ready) begin
          acc_n   = '0;
          ovf_n   = 1'b0;
          cnt_n   = '0;
          state_n = ACC;
        end
      end
      default: state_n = ACC;
    endcase
  end

  assign o_sum = acc;
  assign o_ovf = ovf;
  assign o_cnt = cnt;

endmodule

// File: tb/tb_sklansky_frame_acc.sv
// Directed self-checking bench for sklansky_frame_acc.
`timescale 1ns/1ps
module tb_sklansky_frame_acc;

  localparam int CNT_W = 4;

  logic             clk = 1'b0;
  logic             rst;
  logic             in_valid;
  logic             out_ready;
  logic [5:0]       in_data;
  logic             in_last;
  logic             out_valid;
  logic             down_ready;
  logic [5:0]       sum;
  logic             ovf;
  logic [CNT_W-1:0] cnt;

  int errors = 0;
  int checks = 0;
  int results = 0;
  int stalls = 0;

  always #5 clk = ~clk;

  sklansky_frame_acc #(.CNT_W(CNT_W)) dut (
    .i_clk   (clk),
    .i_rst   (rst),
    .i_valid (in_valid),
    .o_ready (out_ready),
    .i_data  (in_data),
    .i_last  (in_last),
    .o_valid (out_valid),
    .i_ready (down_ready),
    .o_sum   (sum),
    .o_ovf   (ovf),
    .o_cnt   (cnt)
  );

  // Result handshakes, sampled mid-cycle while inputs are stable.
  always @(negedge clk) if (!rst && out_valid && down_ready) results++;

  task automatic chk(input string tag, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Present one beat and hold it until accepted; counts refused cycles in stalls.
  task automatic send(input logic [5:0] d, input logic last);
    bit done = 0;
    in_valid = 1'b1;
    in_data  = d;
    in_last  = last;
    for (int k = 0; k < 20 && !done; k++) begin
      done = out_ready;
      step();
      if (!done) stalls++;
    end
    if (!done) chk("send_timeout", 0, 1);
  endtask

  task automatic idle();
    in_valid = 1'b0;
    in_last  = 1'b0;
    in_data  = '0;
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_data = '0; in_last = 1'b0; down_ready = 1'b1;
    step(); step();
    rst = 1'b0;
    chk("rst_valid", out_valid, 0);
    chk("rst_ready", out_ready, 1);
    chk("rst_sum", sum, 0);
    chk("rst_ovf", ovf, 0);
    chk("rst_cnt", cnt, 0);

    // Frame 5,10,20
    send(5, 0); send(10, 0); send(20, 1);
    chk("f1_valid", out_valid, 1);
    chk("f1_ready", out_ready, 0);
    chk("f1_sum", sum, 35);
    chk("f1_ovf", ovf, 0);
    chk("f1_cnt", cnt, 3);
    idle(); step();
    chk("f1_back_acc", out_valid, 0);
    chk("f1_cleared", cnt, 0);

    // Frame 40,30 wraps past 63
    send(40, 0); send(30, 1); idle();
    chk("f2_valid", out_valid, 1);
`ifdef SKLANSKY_FRAME_ACC_SAT_EN
    chk("f2_sum", sum, 63);
`else
    chk("f2_sum", sum, 6);
`endif
    chk("f2_ovf", ovf, 1);
    chk("f2_cnt", cnt, 2);
    step();

    // Single-beat 63 frame with downstream stalled; extra beats must be ignored
    down_ready = 1'b0;
    send(63, 1);
    in_valid = 1'b1; in_data = 6'd5; in_last = 1'b0;
    for (int k = 0; k < 4; k++) begin
      step();
      chk("f3_valid", out_valid, 1);
      chk("f3_sum", sum, 63);
      chk("f3_ready", out_ready, 0);
      chk("f3_cnt", cnt, 1);
    end
    chk("f3_ovf", ovf, 0);
    idle(); down_ready = 1'b1; step();
    chk("f3_released", out_valid, 0);
    chk("f3_acc_zero", sum, 0);
    send(2, 1); idle();
    chk("f3_next_sum", sum, 2);
    step();

    // 17 ones: counter saturates, sum keeps going
    for (int k = 0; k < 17; k++) send(1, k == 16);
    idle();
    chk("f4_cnt_sat", cnt, 15);
    chk("f4_sum", sum, 17);
    chk("f4_ovf", ovf, 0);
    step();
    chk("results_before_rst", results, 5);

    // Reset mid-frame discards 7+8
    send(7, 0); send(8, 0); idle();
    rst = 1'b1; step(); rst = 1'b0;
    chk("mrst_sum", sum, 0);
    chk("mrst_cnt", cnt, 0);
    chk("mrst_valid", out_valid, 0);
    send(9, 1); idle();
    chk("f5_sum", sum, 9);
    chk("f5_cnt", cnt, 1);
    step();
    chk("results_after_rst", results, 6);

    // Back-to-back frames with valid held high
    stalls = 0;
    send(1, 0); send(2, 1);
    chk("b1_sum", sum, 3);
    chk("b1_valid", out_valid, 1);
    send(3, 0); send(4, 1);
    chk("b2_sum", sum, 7);
    chk("b2_cnt", cnt, 2);
    send(10, 1);
    chk("b3_sum", sum, 10);
    chk("b_stalls", stalls, 2);
    idle(); step();
    chk("results_final", results, 9);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
